// File: rtl/tqvp_reg_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_reg_bus_arbiter_if
// Brief    : Requester A/B, peripheral register port and status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface tqvp_reg_bus_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              a_req;
    logic              a_we;
    logic [1:0]        a_txn;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              a_done;
    logic              a_err;
    logic [31:0]       a_rdata;

    logic              b_req;
    logic              b_we;
    logic [1:0]        b_txn;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_wdata;
    logic              b_done;
    logic              b_err;
    logic [31:0]       b_rdata;

    logic [ADDR_W-1:0] p_address;
    logic [31:0]       p_data_in;
    logic [1:0]        p_data_write_n;
    logic [1:0]        p_data_read_n;
    logic [31:0]       p_data_out;
    logic              p_data_ready;

    logic              busy;
    logic              owner_b;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_txn, a_addr, a_wdata,
        input  b_req, b_we, b_txn, b_addr, b_wdata,
        input  p_data_out, p_data_ready,
        output a_done, a_err, a_rdata,
        output b_done, b_err, b_rdata,
        output p_address, p_data_in, p_data_write_n, p_data_read_n,
        output busy, owner_b
    );

    // Requesters and peripheral side
    modport master (
        output a_req, a_we, a_txn, a_addr, a_wdata,
        output b_req, b_we, b_txn, b_addr, b_wdata,
        output p_data_out, p_data_ready,
        input  a_done, a_err, a_rdata,
        input  b_done, b_err, b_rdata,
        input  p_address, p_data_in, p_data_write_n, p_data_read_n,
        input  busy, owner_b
    );
endinterface
`default_nettype wire

// File: rtl/tqvp_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_reg_bus_arbiter
// Brief    : Round-robin share of one TinyQV peripheral register port between
//            requesters A and B, with width masking and read timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_reg_bus_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tqvp_reg_bus_arbiter_if.slave bus
);
    localparam int                 c_CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]         c_STROBE_IDLE = 2'b11;
    localparam logic [1:0]         c_TXN_INVALID = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_txn;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_prio_b;
    logic                r_owner_b;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_address;
    logic [31:0]         r_data_in;
    logic [1:0]          r_write_n;
    logic [1:0]          r_read_n;
    logic                r_a_done;
    logic                r_a_err;
    logic [31:0]         r_a_rdata;
    logic                r_b_done;
    logic                r_b_err;
    logic [31:0]         r_b_rdata;

    logic                w_any;
    logic                w_grant_b;
    logic                w_we;
    logic [1:0]          w_txn;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic [31:0]         w_masked;
    logic                w_timeout;
    logic                w_fin;
    logic                w_fin_b;
    logic                w_fin_err;
    logic [31:0]         w_fin_rdata;

    // When both request, the pointer names the port that lost last time.
    assign w_any     = bus.a_req | bus.b_req;
    assign w_grant_b = bus.b_req & (~bus.a_req | r_prio_b);
    assign w_we      = w_grant_b ? bus.b_we    : bus.a_we;
    assign w_txn     = w_grant_b ? bus.b_txn   : bus.a_txn;
    assign w_addr    = w_grant_b ? bus.b_addr  : bus.a_addr;
    assign w_wdata   = w_grant_b ? bus.b_wdata : bus.a_wdata;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_comb begin
        case (r_txn)
            2'b00:   w_masked = {24'd0, bus.p_data_out[7:0]};
            2'b01:   w_masked = {16'd0, bus.p_data_out[15:0]};
            default: w_masked = bus.p_data_out;
        endcase
    end

    // Completion decided this cycle; the pulse appears in the DONE cycle.
    always_comb begin
        w_fin       = 1'b0;
        w_fin_b     = r_owner_b;
        w_fin_err   = 1'b0;
        w_fin_rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_any && (w_txn == c_TXN_INVALID)) begin
                    w_fin     = 1'b1;
                    w_fin_b   = w_grant_b;
                    w_fin_err = 1'b1;
                end
            end
            S_WRITE: w_fin = 1'b1;
            S_READ: begin
                if (bus.p_data_ready) begin
                    w_fin       = 1'b1;
                    w_fin_rdata = w_masked;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txn     <= 2'b00;
            r_cnt     <= '0;
            r_prio_b  <= 1'b0;
            r_owner_b <= 1'b0;
            r_busy    <= 1'b0;
            r_address <= '0;
            r_data_in <= 32'd0;
            r_write_n <= c_STROBE_IDLE;
            r_read_n  <= c_STROBE_IDLE;
            r_a_done  <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_rdata <= 32'd0;
            r_b_done  <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_rdata <= 32'd0;
        end else begin
            r_a_done <= w_fin & ~w_fin_b;
            r_b_done <= w_fin &  w_fin_b;
            r_a_err  <= w_fin & ~w_fin_b & w_fin_err;
            r_b_err  <= w_fin &  w_fin_b & w_fin_err;
            if (w_fin && !w_fin_b) begin
                r_a_rdata <= w_fin_rdata;
            end
            if (w_fin && w_fin_b) begin
                r_b_rdata <= w_fin_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner_b <= w_grant_b;
                        r_prio_b  <= ~w_grant_b;
                        r_txn     <= w_txn;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_txn == c_TXN_INVALID) begin
                            r_state <= S_DONE;
                        end else begin
                            r_address <= w_addr;
                            r_data_in <= w_wdata;
                            if (w_we) begin
                                r_state   <= S_WRITE;
                                r_write_n <= w_txn;
                            end else begin
                                r_state  <= S_READ;
                                r_read_n <= w_txn;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_write_n <= c_STROBE_IDLE;
                    r_state   <= S_DONE;
                end
                S_READ: begin
                    if (w_fin) begin
                        r_read_n <= c_STROBE_IDLE;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.p_address      = r_address;
    assign bus.p_data_in      = r_data_in;
    assign bus.p_data_write_n = r_write_n;
    assign bus.p_data_read_n  = r_read_n;
    assign bus.a_done         = r_a_done;
    assign bus.a_err          = r_a_err;
    assign bus.a_rdata        = r_a_rdata;
    assign bus.b_done         = r_b_done;
    assign bus.b_err          = r_b_err;
    assign bus.b_rdata        = r_b_rdata;
    assign bus.busy           = r_busy;
    assign bus.owner_b        = r_owner_b;
endmodule
`default_nettype wire

// File: tb/tb_tqvp_reg_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tqvp_reg_bus_arbiter
// Brief    : Transaction-level model of two requesters and a peripheral.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tqvp_reg_bus_arbiter;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tqvp_reg_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    tqvp_reg_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    logic              pend      [2];
    logic              req_lvl   [2];
    logic              q_we      [2];
    logic [1:0]        q_txn     [2];
    logic [ADDR_W-1:0] q_addr    [2];
    logic [31:0]       q_wdata   [2];
    logic [31:0]       exp_rdata [2];
    logic              known     [2];
    int                done_cnt  [2];
    logic              prio_b;
    int                served;

    int          start_pct     = 0;
    int          force_we      = -1;
    logic        allow_invalid = 1'b1;
    logic        allow_drop    = 1'b0;
    int          force_d       = -1;
    logic        use_dout      = 1'b0;
    logic [31:0] forced_dout   = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] width_view(input logic [1:0] txn, input logic [31:0] d);
        if (txn == 2'b00) return d % 256;
        if (txn == 2'b01) return d % 65536;
        return d;
    endfunction

    task automatic apply();
        bus.a_req = req_lvl[0]; bus.a_we = q_we[0]; bus.a_txn = q_txn[0];
        bus.a_addr = q_addr[0]; bus.a_wdata = q_wdata[0];
        bus.b_req = req_lvl[1]; bus.b_we = q_we[1]; bus.b_txn = q_txn[1];
        bus.b_addr = q_addr[1]; bus.b_wdata = q_wdata[1];
    endtask

    task automatic start(input int p, input logic we, input logic [1:0] txn,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        pend[p] = 1'b1; req_lvl[p] = 1'b1;
        q_we[p] = we; q_txn[p] = txn; q_addr[p] = addr; q_wdata[p] = wdata;
        apply();
    endtask

    task automatic maybe_start(input int p);
        logic we;
        if (!pend[p] && ($urandom_range(99) < start_pct)) begin
            we = (force_we < 0) ? 1'($urandom_range(1)) : 1'(force_we);
            start(p, we, 2'($urandom_range(allow_invalid ? 3 : 2)), ADDR_W'($urandom), $urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_a_done"}, bus.a_done, 0);
        check({tag, "_b_done"}, bus.b_done, 0);
    endtask

    task automatic finish_done(input int w, input logic err, input logic is_read, input logic [31:0] rdata);
        int o = 1 - w;
        check("done_owner", w ? bus.b_done : bus.a_done, 1);
        check("done_other", o ? bus.b_done : bus.a_done, 0);
        check("err_owner",  w ? bus.b_err  : bus.a_err,  err);
        check("err_other",  o ? bus.b_err  : bus.a_err,  0);
        check("busy_done", bus.busy, 1);
        if (is_read) begin
            check("rdata", w ? bus.b_rdata : bus.a_rdata, rdata);
            exp_rdata[w] = rdata;
            known[w]     = 1'b1;
        end else begin
            known[w] = 1'b0;
        end
        if (known[o]) check("rdata_hold", o ? bus.b_rdata : bus.a_rdata, exp_rdata[o]);
        done_cnt[w]++;
        served++;
        pend[w] = 1'b0; req_lvl[w] = 1'b0;
        apply();
        maybe_start(w);
        if (allow_drop) begin
            bus.p_data_ready = 1'($urandom_range(1));
            bus.p_data_out   = $urandom;
        end
        tick();
        check("busy_idle", bus.busy, 0);
        check("idle_wn", bus.p_data_write_n, 2'b11);
        check("idle_rn", bus.p_data_read_n, 2'b11);
        check_quiet("idle");
    endtask

    task automatic serve(input int w);
        int          d;
        logic [31:0] dout;
        logic [1:0]  txn;
        txn = q_txn[w];
        check("owner_b", bus.owner_b, w);
        prio_b = (w == 0);
        if (allow_drop && $urandom_range(3) == 0) begin
            req_lvl[w] = 1'b0;
            apply();
        end
        if (txn == 2'b11) begin
            check("inv_wn", bus.p_data_write_n, 2'b11);
            check("inv_rn", bus.p_data_read_n, 2'b11);
            finish_done(w, 1'b1, 1'b0, 32'd0);
        end else if (q_we[w]) begin
            check("wr_wn", bus.p_data_write_n, txn);
            check("wr_rn", bus.p_data_read_n, 2'b11);
            check("wr_addr", bus.p_address, q_addr[w]);
            check("wr_data", bus.p_data_in, q_wdata[w]);
            check_quiet("wr");
            maybe_start(1 - w);
            tick();
            check("wr_end_wn", bus.p_data_write_n, 2'b11);
            finish_done(w, 1'b0, 1'b0, 32'd0);
        end else begin
            d    = (force_d >= 0) ? force_d :
                   (($urandom_range(3) == 0) ? 1000 : int'($urandom_range(TIMEOUT + 2)));
            dout = use_dout ? forced_dout : $urandom;
            for (int k = 0; k < TIMEOUT; k++) begin
                check("rd_rn", bus.p_data_read_n, txn);
                check("rd_wn", bus.p_data_write_n, 2'b11);
                check("rd_addr", bus.p_address, q_addr[w]);
                check("rd_busy", bus.busy, 1);
                check_quiet("rd");
                maybe_start(1 - w);
                bus.p_data_ready = (k == d);
                bus.p_data_out   = (k == d) ? dout : $urandom;
                tick();
                if (k == d) break;
            end
            bus.p_data_ready = 1'b0;
            check("rd_end_rn", bus.p_data_read_n, 2'b11);
            if (d < TIMEOUT) finish_done(w, 1'b0, 1'b1, width_view(txn, dout));
            else             finish_done(w, 1'b1, 1'b1, 32'd0);
        end
    endtask

    task automatic run(input int max_cycles, input int target);
        logic wa, wb;
        int   goal;
        goal = served + target;
        for (int c = 0; c < max_cycles && served < goal; c++) begin
            if (start_pct == 0 && !pend[0] && !pend[1]) break;
            maybe_start(0);
            maybe_start(1);
            wa = req_lvl[0];
            wb = req_lvl[1];
            tick();
            check("grant_busy", bus.busy, wa | wb);
            if (bus.busy && (wa || wb)) serve((wb && (!wa || prio_b)) ? 1 : 0);
            else check_quiet("wait");
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; req_lvl[p] = 0; q_we[p] = 0; q_txn[p] = 0;
            q_addr[p] = '0; q_wdata[p] = 0; exp_rdata[p] = 0; known[p] = 1; done_cnt[p] = 0;
        end
        prio_b = 1'b0;
        served = 0;
        bus.p_data_out   = 32'd0;
        bus.p_data_ready = 1'b0;
        apply();

        // Reset values
        repeat (3) tick();
        check("rst_wn", bus.p_data_write_n, 2'b11);
        check("rst_rn", bus.p_data_read_n, 2'b11);
        check("rst_addr", bus.p_address, 0);
        check("rst_din", bus.p_data_in, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner_b, 0);
        check("rst_a_rdata", bus.a_rdata, 0);
        check("rst_b_rdata", bus.b_rdata, 0);
        check("rst_errs", {bus.a_err, bus.b_err}, 0);
        check_quiet("rst");
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a B read
        start(1, 1'b0, 2'b10, 6'h2A, 32'd0);
        tick();
        check("t1_busy", bus.busy, 1);
        check("t1_owner", bus.owner_b, 1);
        check("t1_rn", bus.p_data_read_n, 2'b10);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t1_rn_rst", bus.p_data_read_n, 2'b11);
        check("t1_busy_rst", bus.busy, 0);
        check("t1_owner_rst", bus.owner_b, 0);
        check_quiet("t1_rst");
        pend[1] = 0; req_lvl[1] = 0;
        apply();
        prio_b = 1'b0;
        tick();
        check_quiet("t1_hold");
        rst_n = 1'b1;
        tick();

        // Single A byte write
        start(0, 1'b1, 2'b00, 6'h05, 32'hDEADBEEF);
        run(50, 1);

        // Both requesting back-to-back writes
        done_cnt[0] = 0; done_cnt[1] = 0;
        force_we = 1; allow_invalid = 1'b0; start_pct = 100;
        start(0, 1'b1, 2'($urandom_range(2)), ADDR_W'($urandom), $urandom);
        start(1, 1'b1, 2'($urandom_range(2)), ADDR_W'($urandom), $urandom);
        run(100, 8);
        check("t3_a_dones", done_cnt[0], 4);
        check("t3_b_dones", done_cnt[1], 4);
        start_pct = 0; force_we = -1; allow_invalid = 1'b1;
        run(100, 4);

        // B half read, ready on the fourth READ cycle
        force_d = 3; use_dout = 1'b1; forced_dout = 32'h12345678;
        start(1, 1'b0, 2'b01, 6'h11, 32'd0);
        run(50, 1);

        // A read that never completes
        force_d = 1000;
        start(0, 1'b0, 2'b10, 6'h3F, 32'd0);
        run(50, 1);

        // Invalid A txn, then a B word read
        force_d = -1; forced_dout = 32'hCAFEF00D;
        start(0, 1'b1, 2'b11, 6'h01, 32'h1);
        run(50, 1);
        force_d = 2;
        start(1, 1'b0, 2'b10, 6'h22, 32'd0);
        run(50, 1);
        check("t6_owner_hold", bus.owner_b, 1);
        force_d = -1; use_dout = 1'b0;

        // Randomized traffic
        allow_drop = 1'b1; start_pct = 35;
        run(20000, 300);
        start_pct = 0;
        run(500, 1000);
        check("random_served", (served >= 300), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
